reg_scoreboard: RTL and testbench

//  Per-register pending-write scoreboard for the RV64 pipeline. Tracks destination

---
 rtl/reg_scoreboard.sv | 88 ++++++++
 tb/tb_reg_scoreboard.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: per-register busy bit plus a forward-latency countdown.
// Optional stall statistic is built only when SCOREBOARD_STATS_EN is defined.
module reg_scoreboard #(
    parameter int NREG  = 32,
    parameter int LAT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rd,
    input  logic [LAT_W-1:0] issue_lat,
    input  logic             flush,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic [4:0]       rs1_IDR,
    input  logic [4:0]       rs2_IDR,
    input  logic             rs1_used,
    input  logic             rs2_used,
    output logic             no_forwarding_data,
    output logic [NREG-1:0]  busy_vec,
    output logic [31:0]      stall_cycles
);

    logic [NREG-1:0]  busy;
    logic [LAT_W-1:0] cnt [NREG];
    logic             rs1_pending;
    logic             rs2_pending;
    logic             issue_accept;
    logic             wb_hit;
    logic [NREG-1:0]  issue_sel;
    logic [NREG-1:0]  wb_sel;

    // Issue handshake: issue_valid is a one-cycle offer with no ready; it is taken
    // only when IDR is not stalled, not flushed, and the destination is not x0.
    always_comb begin
        rs1_pending = rs1_used && (rs1_IDR != 5'd0) && busy[rs1_IDR] && (cnt[rs1_IDR] != '0);
        rs2_pending = rs2_used && (rs2_IDR != 5'd0) && busy[rs2_IDR] && (cnt[rs2_IDR] != '0);
        no_forwarding_data = rs1_pending || rs2_pending;
        issue_accept = issue_valid && !flush && !no_forwarding_data && (issue_rd != 5'd0);
        wb_hit = wb_valid && (wb_rd != 5'd0);
    end

    always_comb begin
        issue_sel = '0;
        wb_sel    = '0;
        if (issue_accept) issue_sel[issue_rd] = 1'b1;
        if (wb_hit)       wb_sel[wb_rd]       = 1'b1;
    end

    // A newer issue owns the entry even when WB retires the same register this cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (issue_sel[r]) begin
                    busy[r] <= 1'b1;
                    cnt[r]  <= issue_lat;
                end else if (wb_sel[r]) begin
                    busy[r] <= 1'b0;
                    cnt[r]  <= '0;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - LAT_W'(1);
                end
            end
        end
    end

    assign busy_vec = busy;

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (no_forwarding_data && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: hand-computed vector table, a reset
// corner sequence, then random traffic checked against a behavioural model.
module tb_reg_scoreboard;

    localparam int NREG  = 32;
    localparam int LAT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             issue_valid;
    logic [4:0]       issue_rd;
    logic [LAT_W-1:0] issue_lat;
    logic             flush;
    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic [4:0]       rs1_IDR;
    logic [4:0]       rs2_IDR;
    logic             rs1_used;
    logic             rs2_used;
    logic             no_forwarding_data;
    logic [NREG-1:0]  busy_vec;
    logic [31:0]      stall_cycles;

    reg_scoreboard #(.NREG(NREG), .LAT_W(LAT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_lat(issue_lat),
        .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .rs1_IDR(rs1_IDR), .rs2_IDR(rs2_IDR), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .no_forwarding_data(no_forwarding_data), .busy_vec(busy_vec),
        .stall_cycles(stall_cycles)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- records and counters ----------------
    typedef struct {
        logic             iv;
        logic [4:0]       rd;
        logic [LAT_W-1:0] lat;
        logic             fl;
        logic             wv;
        logic [4:0]       wrd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic             u1;
        logic             u2;
        logic             exp_nfd;
        logic [31:0]      exp_busy;
        logic             use_model;
    } rec_t;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    rec_t vec[22];

    // behavioural model of the scoreboard state
    logic             m_busy [NREG];
    logic [LAT_W-1:0] m_cnt  [NREG];
    int               exp_stalls = 0;

    function automatic rec_t mk(logic iv, logic [4:0] rd, logic [LAT_W-1:0] lat, logic fl,
                                logic wv, logic [4:0] wrd, logic [4:0] rs1, logic [4:0] rs2,
                                logic u1, logic u2, logic exp_nfd, logic [31:0] exp_busy);
        rec_t v;
        v.iv = iv; v.rd = rd; v.lat = lat; v.fl = fl; v.wv = wv; v.wrd = wrd;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.exp_nfd = exp_nfd; v.exp_busy = exp_busy; v.use_model = 1'b0;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic m_pend(input logic used, input logic [4:0] rs);
        return used && (rs != 5'd0) && m_busy[rs] && (m_cnt[rs] != '0);
    endfunction

    function automatic logic [31:0] m_vec();
        logic [31:0] b;
        for (int r = 0; r < NREG; r++) b[r] = m_busy[r];
        return b;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            m_busy[r] = 1'b0;
            m_cnt[r]  = '0;
        end
        exp_stalls = 0;
    endtask

    task automatic model_update(input rec_t v);
        logic nfd;
        logic acc;
        nfd = m_pend(v.u1, v.rs1) || m_pend(v.u2, v.rs2);
        acc = v.iv && !v.fl && !nfd && (v.rd != 5'd0);
        for (int r = 1; r < NREG; r++)
            if (m_cnt[r] != '0) m_cnt[r] = m_cnt[r] - 1'b1;
        if (v.wv && (v.wrd != 5'd0) && !(acc && (v.rd == v.wrd))) begin
            m_busy[v.wrd] = 1'b0;
            m_cnt[v.wrd]  = '0;
        end
        if (acc) begin
            m_busy[v.rd] = 1'b1;
            m_cnt[v.rd]  = v.lat;
        end
        if (nfd) exp_stalls++;
    endtask

    function automatic logic [31:0] exp_stat();
`ifdef SCOREBOARD_STATS_EN
        return 32'(exp_stalls);
`else
        return 32'd0;
`endif
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input rec_t v);
        issue_valid = v.iv; issue_rd = v.rd; issue_lat = v.lat; flush = v.fl;
        wb_valid = v.wv; wb_rd = v.wrd;
        rs1_IDR = v.rs1; rs2_IDR = v.rs2; rs1_used = v.u1; rs2_used = v.u2;
    endtask

    // one cycle: drive at negedge, check the combinational stall, predict the
    // post-edge busy vector into the queue, then compare after the edge
    task automatic step(input rec_t v, input string name);
        logic        e_nfd;
        logic [31:0] got;
        @(negedge clk);
        drive(v);
        #1;
        e_nfd = v.use_model ? (m_pend(v.u1, v.rs1) || m_pend(v.u2, v.rs2)) : v.exp_nfd;
        check({name, " nfd"}, 32'(no_forwarding_data), 32'(e_nfd));
        model_update(v);
        exp_q.push_back(v.use_model ? m_vec() : v.exp_busy);
        @(posedge clk);
        #1;
        got = busy_vec;
        if (exp_q.size() == 0) begin
            check({name, " queue"}, 32'd1, 32'd0);
        end else begin
            check({name, " busy_vec"}, got, exp_q.pop_front());
        end
    endtask

    // ---------------- test ----------------
    initial begin
        rec_t idle;
        rec_t v;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        vec[0]  = mk(0, 0,  0, 0, 0, 0,  5,  5, 1, 1, 0, 32'h0000_0000);
        vec[1]  = mk(1, 5,  2, 0, 0, 0,  0,  0, 0, 0, 0, 32'h0000_0020);
        vec[2]  = mk(0, 0,  0, 0, 0, 0,  5,  0, 1, 0, 1, 32'h0000_0020);
        vec[3]  = mk(0, 0,  0, 0, 0, 0,  5,  0, 1, 0, 1, 32'h0000_0020);
        vec[4]  = mk(0, 0,  0, 0, 0, 0,  5,  0, 1, 0, 0, 32'h0000_0020);
        vec[5]  = mk(1, 7,  3, 1, 0, 0,  0,  7, 0, 1, 0, 32'h0000_0020);
        vec[6]  = mk(0, 0,  0, 0, 1, 5,  0,  7, 0, 1, 0, 32'h0000_0000);
        vec[7]  = mk(0, 0,  0, 0, 0, 0,  5,  0, 1, 0, 0, 32'h0000_0000);
        vec[8]  = mk(1, 9,  3, 0, 0, 0,  0,  0, 0, 0, 0, 32'h0000_0200);
        vec[9]  = mk(1, 9,  1, 0, 1, 9,  0,  0, 0, 0, 0, 32'h0000_0200);
        vec[10] = mk(0, 0,  0, 0, 0, 0,  9,  0, 1, 0, 1, 32'h0000_0200);
        vec[11] = mk(0, 0,  0, 0, 0, 0,  9,  0, 1, 0, 0, 32'h0000_0200);
        vec[12] = mk(1, 0,  7, 0, 0, 0,  0,  0, 1, 0, 0, 32'h0000_0200);
        vec[13] = mk(0, 0,  0, 0, 0, 0,  0,  0, 1, 1, 0, 32'h0000_0200);
        vec[14] = mk(1, 11, 4, 0, 0, 0,  0,  0, 0, 0, 0, 32'h0000_0A00);
        vec[15] = mk(1, 12, 5, 0, 0, 0,  0, 11, 0, 1, 1, 32'h0000_0A00);
        vec[16] = mk(1, 12, 0, 0, 0, 0,  0,  0, 0, 0, 0, 32'h0000_1A00);
        vec[17] = mk(0, 0,  0, 0, 0, 0, 12, 11, 1, 0, 0, 32'h0000_1A00);
        vec[18] = mk(0, 0,  0, 0, 0, 0,  0, 11, 0, 1, 1, 32'h0000_1A00);
        vec[19] = mk(0, 0,  0, 0, 1, 11, 0,  0, 0, 0, 0, 32'h0000_1200);
        vec[20] = mk(0, 0,  0, 0, 1, 9, 11,  0, 1, 0, 0, 32'h0000_1000);
        vec[21] = mk(0, 0,  0, 0, 1, 0,  0,  0, 0, 0, 0, 32'h0000_1000);

        // reset block
        rst_n = 1'b0;
        drive(idle);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset busy_vec", busy_vec, 32'd0);
        check("reset nfd", 32'(no_forwarding_data), 32'd0);
        check("reset stall_cycles", stall_cycles, 32'd0);

        for (int i = 0; i < 22; i++) step(vec[i], $sformatf("vec%0d", i));
        check("table stall_cycles", stall_cycles, exp_stat());

        // reset asserted while an entry is counting and IDR is stalled on it
        step(mk(1, 3, 6, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_1008), "rst_pre_issue");
        step(mk(0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 1, 32'h0000_1008), "rst_pre_stall");
        check("pre-reset stall_cycles", stall_cycles, exp_stat());
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check("midreset busy_vec", busy_vec, 32'd0);
        check("midreset stall_cycles", stall_cycles, 32'd0);
        check("midreset nfd", 32'(no_forwarding_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // random traffic on a small register window to force collisions
        for (int i = 0; i < 400; i++) begin
            v.iv  = ($urandom_range(0, 99) < 60);
            v.rd  = 5'($urandom_range(0, 7));
            v.lat = LAT_W'($urandom_range(0, 15));
            v.fl  = ($urandom_range(0, 99) < 15);
            v.wv  = ($urandom_range(0, 99) < 40);
            v.wrd = 5'($urandom_range(0, 7));
            v.rs1 = 5'($urandom_range(0, 7));
            v.rs2 = 5'($urandom_range(0, 7));
            v.u1  = ($urandom_range(0, 99) < 70);
            v.u2  = ($urandom_range(0, 99) < 50);
            v.exp_nfd = 1'b0;
            v.exp_busy = '0;
            v.use_model = 1'b1;
            step(v, "rand");
        end
        check("final stall_cycles", stall_cycles, exp_stat());
        check("final queue empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // bound the run in case the clock or a step never completes
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected completion");
        $fatal(1);
    end

endmodule
